// File: rtl/voice_allocator_if.sv
// Event and voice-bank signal bundle for the polyphonic voice allocator.
// The slave modport belongs to the allocator; the master modport to the key decoder and voice bank.
interface voice_allocator_if #(
    parameter int unsigned NUM_VOICES = 8,
    parameter int unsigned NOTE_W     = 5
);
    localparam int unsigned IDX_W = $clog2(NUM_VOICES);

    logic                         evt_valid;
    logic                         evt_ready;
    logic                         evt_on;
    logic [NOTE_W-1:0]            evt_note;
    logic [NUM_VOICES-1:0]        voice_idle;
    logic [NUM_VOICES-1:0]        voice_gate;
    logic [NUM_VOICES*NOTE_W-1:0] voice_note;
    logic [NUM_VOICES-1:0]        voice_trigger;
    logic [NUM_VOICES-1:0]        voice_release;
    logic                         steal;
    logic [IDX_W:0]               active_count;

    modport master (
        output evt_valid, evt_on, evt_note, voice_idle,
        input  evt_ready, voice_gate, voice_note, voice_trigger, voice_release,
               steal, active_count
    );

    modport slave (
        input  evt_valid, evt_on, evt_note, voice_idle,
        output evt_ready, voice_gate, voice_note, voice_trigger, voice_release,
               steal, active_count
    );
endinterface

// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler: serial scan picks retrigger, free, released or oldest voice,
// then a single commit cycle updates gates, notes, ages and one-cycle strobes.
module voice_allocator #(
    parameter int unsigned NUM_VOICES = 8,
    parameter int unsigned NOTE_W     = 5
) (
    input logic             clk,
    input logic             reset_n,
    voice_allocator_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(NUM_VOICES);
    localparam int unsigned CNT_W = IDX_W + 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_VOICES - 1);

    typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

    state_t                  state, state_nxt;
    logic [IDX_W-1:0]        scan_idx, scan_nxt;
    logic                    on_q, on_nxt;
    logic [NOTE_W-1:0]       key_q, key_nxt;

    logic                    t1_vld, t1_vld_nxt, t2_vld, t2_vld_nxt, t3_vld, t3_vld_nxt;
    logic [IDX_W-1:0]        t1_idx, t1_nxt, t2_idx, t2_nxt, t3_idx, t3_nxt, t4_idx, t4_nxt;
    logic [IDX_W-1:0]        t3_age, t3_age_nxt;

    logic [NUM_VOICES-1:0]   gate, gate_nxt;
    logic [NOTE_W-1:0]       notes [NUM_VOICES];
    logic [NOTE_W-1:0]       notes_nxt [NUM_VOICES];
    logic [IDX_W-1:0]        age [NUM_VOICES];
    logic [IDX_W-1:0]        age_nxt [NUM_VOICES];
    logic [NUM_VOICES-1:0]   trig, trig_nxt, rel, rel_nxt;
    logic                    steal_q, steal_nxt;
    logic                    ready, ready_nxt;
    logic [CNT_W-1:0]        cnt, cnt_nxt;
    logic [IDX_W-1:0]        win;
    logic                    win_steal;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state, tier scan and commit
    always_comb begin
        state_nxt  = state;
        scan_nxt   = scan_idx;
        on_nxt     = on_q;
        key_nxt    = key_q;
        t1_vld_nxt = t1_vld;
        t2_vld_nxt = t2_vld;
        t3_vld_nxt = t3_vld;
        t1_nxt     = t1_idx;
        t2_nxt     = t2_idx;
        t3_nxt     = t3_idx;
        t3_age_nxt = t3_age;
        t4_nxt     = t4_idx;
        gate_nxt   = gate;
        notes_nxt  = notes;
        age_nxt    = age;
        trig_nxt   = '0;
        rel_nxt    = '0;
        steal_nxt  = 1'b0;
        win        = '0;
        win_steal  = 1'b0;
        cnt_nxt    = '0;

        case (state)
            IDLE: begin
                if (bus.evt_valid && ready) begin
                    on_nxt     = bus.evt_on;
                    key_nxt    = bus.evt_note;
                    scan_nxt   = '0;
                    t1_vld_nxt = 1'b0;
                    t2_vld_nxt = 1'b0;
                    t3_vld_nxt = 1'b0;
                    state_nxt  = SCAN;
                end
            end
            SCAN: begin
                if (!t1_vld && gate[scan_idx] && notes[scan_idx] == key_q) begin
                    t1_vld_nxt = 1'b1;
                    t1_nxt     = scan_idx;
                end
                if (!t2_vld && !gate[scan_idx] && bus.voice_idle[scan_idx]) begin
                    t2_vld_nxt = 1'b1;
                    t2_nxt     = scan_idx;
                end
                // Ages are a permutation, so a strict compare never ties
                if (!gate[scan_idx] && !bus.voice_idle[scan_idx] &&
                    (!t3_vld || age[scan_idx] > t3_age)) begin
                    t3_vld_nxt = 1'b1;
                    t3_nxt     = scan_idx;
                    t3_age_nxt = age[scan_idx];
                end
                if (age[scan_idx] == LAST) t4_nxt = scan_idx;
                if (scan_idx == LAST) state_nxt = COMMIT;
                else                  scan_nxt  = scan_idx + IDX_W'(1);
            end
            COMMIT: begin
                state_nxt = IDLE;
                if (on_q) begin
                    if (t1_vld)      win = t1_idx;
                    else if (t2_vld) win = t2_idx;
                    else if (t3_vld) win = t3_idx;
                    else begin
                        win       = t4_idx;
                        win_steal = 1'b1;
                    end
                    for (int i = 0; i < NUM_VOICES; i++)
                        if (age[i] < age[win]) age_nxt[i] = age[i] + IDX_W'(1);
                    age_nxt[win]   = '0;
                    gate_nxt[win]  = 1'b1;
                    notes_nxt[win] = key_q;
                    trig_nxt[win]  = 1'b1;
                    steal_nxt      = win_steal;
                end else begin
                    for (int i = 0; i < NUM_VOICES; i++) begin
                        if (gate[i] && notes[i] == key_q) begin
                            gate_nxt[i] = 1'b0;
                            rel_nxt[i]  = 1'b1;
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        ready_nxt = (state_nxt == IDLE);
        for (int i = 0; i < NUM_VOICES; i++) cnt_nxt = cnt_nxt + CNT_W'(gate_nxt[i]);
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scan_idx <= '0;
            on_q     <= 1'b0;
            key_q    <= '0;
            t1_vld   <= 1'b0;
            t2_vld   <= 1'b0;
            t3_vld   <= 1'b0;
            t1_idx   <= '0;
            t2_idx   <= '0;
            t3_idx   <= '0;
            t3_age   <= '0;
            t4_idx   <= '0;
            gate     <= '0;
            trig     <= '0;
            rel      <= '0;
            steal_q  <= 1'b0;
            ready    <= 1'b1;
            cnt      <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                notes[i] <= '0;
                age[i]   <= IDX_W'(i);
            end
        end else begin
            scan_idx <= scan_nxt;
            on_q     <= on_nxt;
            key_q    <= key_nxt;
            t1_vld   <= t1_vld_nxt;
            t2_vld   <= t2_vld_nxt;
            t3_vld   <= t3_vld_nxt;
            t1_idx   <= t1_nxt;
            t2_idx   <= t2_nxt;
            t3_idx   <= t3_nxt;
            t3_age   <= t3_age_nxt;
            t4_idx   <= t4_nxt;
            gate     <= gate_nxt;
            trig     <= trig_nxt;
            rel      <= rel_nxt;
            steal_q  <= steal_nxt;
            ready    <= ready_nxt;
            cnt      <= cnt_nxt;
            notes    <= notes_nxt;
            age      <= age_nxt;
        end
    end

    assign bus.evt_ready     = ready;
    assign bus.voice_gate    = gate;
    assign bus.voice_trigger = trig;
    assign bus.voice_release = rel;
    assign bus.steal         = steal_q;
    assign bus.active_count  = cnt;

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_note
        assign bus.voice_note[g*NOTE_W +: NOTE_W] = notes[g];
    end
endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator: tier selection, aging, note-off release and async reset.
module tb_voice_allocator;
    localparam int unsigned NV = 8;
    localparam int unsigned NW = 5;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    voice_allocator_if #(.NUM_VOICES(NV), .NOTE_W(NW)) vif ();

    voice_allocator #(.NUM_VOICES(NV), .NOTE_W(NW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (vif.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] nt(input int i);
        return 32'(vif.voice_note[i*NW +: NW]);
    endfunction

    task automatic exp_out(input string tag, input logic [31:0] gate, input logic [31:0] trig,
                           input logic [31:0] rel, input logic [31:0] stl, input logic [31:0] cnt);
        check({tag, ".gate"},  32'(vif.voice_gate),    gate);
        check({tag, ".trig"},  32'(vif.voice_trigger), trig);
        check({tag, ".rel"},   32'(vif.voice_release), rel);
        check({tag, ".steal"}, 32'(vif.steal),         stl);
        check({tag, ".count"}, 32'(vif.active_count),  cnt);
        check({tag, ".ready"}, 32'(vif.evt_ready),     1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Drives one event and returns #1 into the strobe cycle (accept edge + NV + 1)
    task automatic send(input logic on, input logic [NW-1:0] note);
        @(negedge clk);
        check("ready_pre", 32'(vif.evt_ready), 1);
        vif.evt_valid = 1'b1;
        vif.evt_on    = on;
        vif.evt_note  = note;
        @(posedge clk);
        #1;
        vif.evt_valid = 1'b0;
        check("busy", 32'(vif.evt_ready), 0);
        repeat (NV) @(posedge clk);
        #1;
        check("early_strobe", 32'(vif.voice_trigger | vif.voice_release), 0);
        @(posedge clk);
        #1;
    endtask

    logic [NV-1:0] seen_trig;
    logic          seen_steal;

    initial begin
        vif.evt_valid  = 1'b0;
        vif.evt_on     = 1'b0;
        vif.evt_note   = '0;
        vif.voice_idle = 8'hFF;
        #1;
        check("rst.gate", 32'(vif.voice_gate), 0);
        check("rst.note", 32'(vif.voice_note), 0);
        do_reset();
        exp_out("rst", 0, 0, 0, 0, 0);

        // First note-on lands on free voice 0
        send(1'b1, 5'd5);
        exp_out("on5", 'h01, 'h01, 0, 0, 1);
        check("on5.note0", nt(0), 5);
        @(posedge clk); #1;
        check("on5.trig_clr", 32'(vif.voice_trigger), 0);

        // Fill all voices, then steal the oldest
        do_reset();
        for (int n = 1; n <= 8; n++) send(1'b1, NW'(n));
        check("fill.gate", 32'(vif.voice_gate), 'hFF);
        check("fill.note7", nt(7), 8);
        send(1'b1, 5'd9);
        exp_out("steal9", 'hFF, 'h01, 0, 1, 8);
        check("steal9.note0", nt(0), 9);
        @(posedge clk); #1;
        check("steal9.clr", 32'({vif.steal, vif.voice_trigger}), 0);

        // Note-off matched and unmatched
        do_reset();
        send(1'b1, 5'd3);
        send(1'b1, 5'd4);
        send(1'b1, 5'd5);
        send(1'b0, 5'd4);
        exp_out("off4", 'h05, 0, 'h02, 0, 2);
        check("off4.note1", nt(1), 4);
        @(posedge clk); #1;
        check("off4.rel_clr", 32'(vif.voice_release), 0);
        send(1'b0, 5'd30);
        exp_out("off30", 'h05, 0, 0, 0, 2);

        // Retrigger refreshes age: later steal skips voice 0
        do_reset();
        send(1'b1, 5'd7);
        send(1'b1, 5'd3);
        send(1'b1, 5'd4);
        send(1'b1, 5'd7);
        exp_out("retrig", 'h07, 'h01, 0, 0, 3);
        check("retrig.note0", nt(0), 7);
        for (int n = 10; n <= 14; n++) send(1'b1, NW'(n));
        send(1'b1, 5'd20);
        exp_out("steal20", 'hFF, 'h02, 0, 1, 8);
        check("steal20.note1", nt(1), 20);
        check("steal20.note0", nt(0), 7);

        // Release everything, then released-voice (T3) and idle-voice (T2) selection
        send(1'b0, 5'd7);
        check("off7.rel", 32'(vif.voice_release), 'h01);
        send(1'b0, 5'd20);
        send(1'b0, 5'd4);
        for (int n = 10; n <= 14; n++) send(1'b0, NW'(n));
        exp_out("alloff", 0, 0, 'h80, 0, 0);
        vif.voice_idle = 8'h00;
        send(1'b1, 5'd25);
        exp_out("t3", 'h04, 'h04, 0, 0, 1);
        check("t3.note2", nt(2), 25);
        vif.voice_idle = 8'h20;
        send(1'b1, 5'd26);
        exp_out("t2", 'h24, 'h20, 0, 0, 2);
        check("t2.note5", nt(5), 26);

        // Async reset in the middle of a scan
        @(negedge clk);
        vif.evt_valid = 1'b1;
        vif.evt_on    = 1'b1;
        vif.evt_note  = 5'd11;
        @(posedge clk); #1;
        vif.evt_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        exp_out("midrst", 0, 0, 0, 0, 0);
        check("midrst.note", 32'(vif.voice_note[31:0]), 0);
        @(negedge clk);
        reset_n = 1'b1;
        seen_trig  = '0;
        seen_steal = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            seen_trig  = seen_trig | vif.voice_trigger;
            seen_steal = seen_steal | vif.steal;
        end
        check("midrst.no_strobe", 32'({seen_steal, seen_trig}), 0);
        vif.voice_idle = 8'h00;
        send(1'b1, 5'd17);
        exp_out("age_rst", 'h80, 'h80, 0, 0, 1);
        check("age_rst.note7", nt(7), 17);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
